// File: rtl/health_tracker.sv
// health_tracker
//   Player-health controller for the asteroid game. Health is held as DIGITS
//   packed BCD digits. Hits come from a raw asynchronous toggle input, are
//   synchronised, and apply a variable BCD damage. The block also supports
//   heal, an invulnerability window after each non-fatal hit, and restart.
//   On death it drives the game-over enables.
//
//   Optional build macro: HEALTH_REGEN_EN
//     defined   -> health regenerates by 1 every REGEN_CYCLES cycles in ALIVE
//     undefined -> no regen counter; health changes only via hit/heal/restart
//
// Ports
//   clk           in   system clock, rising edge
//   reset         in   asynchronous, active-low
//   health_toggle in   raw async hit input; each rising edge is one hit
//   damage[3:0]   in   BCD damage per hit (0 -> 1, 10..15 -> 9)
//   heal          in   +1 health per cycle high (saturates at MAX_HEALTH)
//   restart       in   reload START_HEALTH from any state
//   health_bcd    out  registered BCD health, digit 0 in [3:0]
//   invuln        out  high while in INVULN
//   dead          out  high while in DEAD
//   enable        out  all ones while in DEAD
//   hit_ack       out  one-cycle pulse following each accepted hit
//
// Handshake note: there is no valid/ready pair on this block. A hit is a
// single-cycle strobe derived from the synchronised toggle; it is either
// accepted (ALIVE, acknowledged by hit_ack the next cycle) or silently
// dropped (INVULN, DEAD). Nothing is ever queued.
//
// The FSM state is fully visible on the outputs: {dead, invuln} = 00 ALIVE,
// 01 INVULN, 10 DEAD.

module health_tracker #(
  parameter int DIGITS        = 2,
  parameter int START_HEALTH  = 10,
  parameter int MAX_HEALTH    = 99,
  parameter int ENABLES       = 5,
  parameter int INVULN_CYCLES = 8,
  parameter int REGEN_CYCLES  = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  health_toggle,
  input  logic [3:0]            damage,
  input  logic                  heal,
  input  logic                  restart,
  output logic [4*DIGITS-1:0]   health_bcd,
  output logic                  invuln,
  output logic                  dead,
  output logic [ENABLES-1:0]    enable,
  output logic                  hit_ack
);

  localparam int HW = 4 * DIGITS;
  localparam int CW = (INVULN_CYCLES > 0) ? $clog2(INVULN_CYCLES + 1) : 1;

  function automatic logic [HW-1:0] to_bcd(input int value);
    logic [HW-1:0] r;
    int v;
    r = '0;
    v = value;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  localparam logic [HW-1:0] START_BCD = to_bcd(START_HEALTH);
  localparam logic [HW-1:0] MAX_BCD   = to_bcd(MAX_HEALTH);

  typedef enum logic [1:0] {
    ALIVE  = 2'd0,
    INVULN = 2'd1,
    DEAD   = 2'd2
  } state_t;

  state_t         state;
  logic [CW-1:0]  cooldown;
  logic           s1, s2, s3;
  logic           hit;
  logic [3:0]     dmg_eff;
  logic [HW-1:0]  sub_result;
  logic           sub_fatal;
  logic [4:0]     sub_t;
  logic           sub_borrow;
  logic [HW-1:0]  add_result;
  logic           add_carry;
  logic           at_max;
  logic           regen_fire;

  // Sync flops reset to 1 so a toggle already high at reset release is not
  // seen as a rising edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= health_toggle;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign hit = s2 & ~s3;

  always_comb begin
    if (damage == 4'd0)     dmg_eff = 4'd1;
    else if (damage > 4'd9) dmg_eff = 4'd9;
    else                    dmg_eff = damage;
  end

  // Digit-serial BCD subtract. A borrow out of the top digit, or an exact
  // zero, means damage >= health: the hit is fatal.
  always_comb begin
    sub_result = '0;
    sub_borrow = 1'b0;
    sub_t      = '0;
    for (int i = 0; i < DIGITS; i++) begin
      sub_t = {1'b0, health_bcd[4*i +: 4]}
            - {1'b0, ((i == 0) ? dmg_eff : 4'd0)}
            - {4'b0000, sub_borrow};
      if (sub_t[4]) begin
        sub_t      = sub_t + 5'd10;
        sub_borrow = 1'b1;
      end else begin
        sub_borrow = 1'b0;
      end
      sub_result[4*i +: 4] = sub_t[3:0];
    end
    sub_fatal = sub_borrow || (sub_result == '0);
  end

  // BCD increment. Only used when health < MAX_HEALTH, so no overflow.
  always_comb begin
    add_result = health_bcd;
    add_carry  = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (add_carry) begin
        if (health_bcd[4*i +: 4] == 4'd9) begin
          add_result[4*i +: 4] = 4'd0;
        end else begin
          add_result[4*i +: 4] = health_bcd[4*i +: 4] + 4'd1;
          add_carry = 1'b0;
        end
      end
    end
  end

  assign at_max = (health_bcd == MAX_BCD);

`ifdef HEALTH_REGEN_EN
  localparam int RW = (REGEN_CYCLES > 1) ? $clog2(REGEN_CYCLES) : 1;
  logic [RW-1:0] regen_cnt;

  // Free-running only in ALIVE; cleared by an accepted hit or restart.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regen_cnt <= '0;
    end else if (restart || (state != ALIVE) || hit) begin
      regen_cnt <= '0;
    end else if (regen_cnt == RW'(REGEN_CYCLES - 1)) begin
      regen_cnt <= '0;
    end else begin
      regen_cnt <= regen_cnt + 1'b1;
    end
  end

  assign regen_fire = (state == ALIVE) && (regen_cnt == RW'(REGEN_CYCLES - 1));
`else
  assign regen_fire = 1'b0;
`endif

  // Priority inside ALIVE: hit > heal > regen. Restart overrides everything.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ALIVE;
      health_bcd <= START_BCD;
      invuln     <= 1'b0;
      dead       <= 1'b0;
      enable     <= '0;
      hit_ack    <= 1'b0;
      cooldown   <= '0;
    end else begin
      hit_ack <= 1'b0;
      if (restart) begin
        state      <= ALIVE;
        health_bcd <= START_BCD;
        invuln     <= 1'b0;
        dead       <= 1'b0;
        enable     <= '0;
        cooldown   <= '0;
      end else begin
        case (state)
          ALIVE: begin
            if (hit) begin
              hit_ack <= 1'b1;
              if (sub_fatal) begin
                health_bcd <= '0;
                state      <= DEAD;
                dead       <= 1'b1;
                enable     <= '1;
              end else begin
                health_bcd <= sub_result;
                if (INVULN_CYCLES > 0) begin
                  state    <= INVULN;
                  invuln   <= 1'b1;
                  cooldown <= CW'(INVULN_CYCLES);
                end
              end
            end else if (heal) begin
              if (!at_max) health_bcd <= add_result;
            end else if (regen_fire) begin
              if (!at_max) health_bcd <= add_result;
            end
          end
          INVULN: begin
            // Hits are dropped here; heal still applies.
            if (heal && !at_max) health_bcd <= add_result;
            if (cooldown <= CW'(1)) begin
              state    <= ALIVE;
              invuln   <= 1'b0;
              cooldown <= '0;
            end else begin
              cooldown <= cooldown - 1'b1;
            end
          end
          DEAD: begin
            // Only restart or reset leaves DEAD.
          end
          default: begin
            state <= ALIVE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_health_tracker.sv
module tb_health_tracker;

  localparam int DIGITS = 2;
  localparam int START  = 10;
  localparam int MAXH   = 99;
  localparam int EN     = 5;
  localparam int INV    = 8;
  localparam int OW     = 4*DIGITS + 3 + EN;

  // ---------------- clock / reset / DUT ----------------
  logic                clk = 1'b0;
  logic                reset;
  logic                health_toggle;
  logic [3:0]          damage;
  logic                heal;
  logic                restart;
  logic [4*DIGITS-1:0] health_bcd;
  logic                invuln;
  logic                dead;
  logic [EN-1:0]       enable;
  logic                hit_ack;
  logic [OW-1:0]       obs;

  always #5 clk = ~clk;

  health_tracker #(
    .DIGITS(DIGITS), .START_HEALTH(START), .MAX_HEALTH(MAXH),
    .ENABLES(EN), .INVULN_CYCLES(INV), .REGEN_CYCLES(1024)
  ) dut (
    .clk(clk), .reset(reset), .health_toggle(health_toggle),
    .damage(damage), .heal(heal), .restart(restart),
    .health_bcd(health_bcd), .invuln(invuln), .dead(dead),
    .enable(enable), .hit_ack(hit_ack)
  );

  assign obs = {health_bcd, invuln, dead, enable, hit_ack};

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  // Health as a plain integer, invulnerability as remaining cycles, and the
  // raw toggle samples of the last three edges (a hit is a 0->1 step seen
  // two edges late).
  int m_health;
  int m_cool;
  bit m_dead;
  bit m_ack;
  bit samp1, samp2, samp3;

  logic [OW-1:0] exp_q[$];
  logic [OW-1:0] act_q[$];

  function automatic logic [4*DIGITS-1:0] to_bcd(input int value);
    logic [4*DIGITS-1:0] r;
    int v;
    r = '0;
    v = value;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [OW-1:0] model_vec();
    logic [EN-1:0] en;
    en = m_dead ? '1 : '0;
    return {to_bcd(m_health), (m_cool > 0), m_dead, en, m_ack};
  endfunction

  task automatic model_reset();
    m_health = START;
    m_cool   = 0;
    m_dead   = 1'b0;
    m_ack    = 1'b0;
    samp1 = 1'b1; samp2 = 1'b1; samp3 = 1'b1;
  endtask

  task automatic model_edge();
    bit h;
    int d;
    h = samp2 && !samp3;
    samp3 = samp2; samp2 = samp1; samp1 = health_toggle;
    d = (damage == 0) ? 1 : ((damage > 9) ? 9 : int'(damage));
    m_ack = 1'b0;
    if (restart) begin
      m_health = START; m_dead = 1'b0; m_cool = 0;
    end else if (m_dead) begin
      // ignore everything
    end else if (m_cool > 0) begin
      m_cool--;
      if (heal && m_health < MAXH) m_health++;
    end else if (h) begin
      m_ack = 1'b1;
      if (d >= m_health) begin
        m_health = 0; m_dead = 1'b1;
      end else begin
        m_health = m_health - d;
        m_cool   = INV;
      end
    end else if (heal && m_health < MAXH) begin
      m_health++;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    model_edge();
    exp_q.push_back(model_vec());
    #1;
    act_q.push_back(obs);
  endtask

  task automatic hit_edge(input logic [3:0] dmg);
    damage = dmg;
    health_toggle = 1'b1; tick();
    health_toggle = 1'b0; tick();
    tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [OW-1:0] e, a;
    reset = 1'b0; health_toggle = 1'b1; damage = 4'd0;
    heal = 1'b0; restart = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (obs !== {8'h10, 1'b0, 1'b0, 5'b00000, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got %h expected %h", obs, {8'h10, 8'h00});
    end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (hit_ack !== 1'b0) begin
        errors++;
        $display("FAIL reset_toggle_high_ack: got %b expected 0", hit_ack);
      end
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL reset_release: got %h expected %h", a, e);
      end
    end
  endtask

  task automatic test_hit_invuln();
    logic [OW-1:0] e, a;
    int inv_count;
    health_toggle = 1'b0; damage = 4'd3;
    tick(); tick();
    hit_edge(4'd3);
    checks++;
    if ({health_bcd, hit_ack, invuln} !== {8'h07, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL first_hit: got %h/%b/%b expected 07/1/1", health_bcd, hit_ack, invuln);
    end
    inv_count = 1;
    for (int i = 0; i < 12; i++) begin
      health_toggle = (i == 1);
      tick();
      if (invuln) inv_count++;
    end
    checks++;
    if (inv_count != INV) begin
      errors++;
      $display("FAIL invuln_len: got %0d expected %0d", inv_count, INV);
    end
    checks++;
    if (health_bcd !== 8'h07) begin
      errors++;
      $display("FAIL hit_in_window: got %h expected 07", health_bcd);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL hit_invuln: got %h expected %h", a, e);
      end
    end
  endtask

  task automatic test_borrow_heal();
    logic [OW-1:0] e, a;
    restart = 1'b1; tick(); restart = 1'b0;
    heal = 1'b1; tick(); tick(); heal = 1'b0;
    hit_edge(4'd3);
    checks++;
    if (health_bcd !== 8'h09) begin
      errors++;
      $display("FAIL bcd_borrow: got %h expected 09", health_bcd);
    end
    heal = 1'b1; tick(); tick(); heal = 1'b0;
    checks++;
    if (health_bcd !== 8'h11) begin
      errors++;
      $display("FAIL heal_in_invuln: got %h expected 11", health_bcd);
    end
    heal = 1'b1;
    repeat (95) tick();
    heal = 1'b0;
    checks++;
    if (health_bcd !== 8'h99) begin
      errors++;
      $display("FAIL heal_saturate: got %h expected 99", health_bcd);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL borrow_heal: got %h expected %h", a, e);
      end
    end
  endtask

  task automatic test_death();
    logic [OW-1:0] e, a;
    restart = 1'b1; tick(); restart = 1'b0;
    hit_edge(4'd5);
    repeat (9) tick();
    checks++;
    if ({health_bcd, invuln} !== {8'h05, 1'b0}) begin
      errors++;
      $display("FAIL pre_death: got %h/%b expected 05/0", health_bcd, invuln);
    end
    hit_edge(4'd7);
    checks++;
    if ({health_bcd, dead, enable, hit_ack} !== {8'h00, 1'b1, 5'b11111, 1'b1}) begin
      errors++;
      $display("FAIL death: got %h/%b/%b/%b expected 00/1/11111/1", health_bcd, dead, enable, hit_ack);
    end
    heal = 1'b1; repeat (3) tick(); heal = 1'b0;
    hit_edge(4'd2);
    checks++;
    if ({health_bcd, dead, hit_ack} !== {8'h00, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL dead_ignores: got %h/%b/%b expected 00/1/0", health_bcd, dead, hit_ack);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL death_seq: got %h expected %h", a, e);
      end
    end
  endtask

  task automatic test_hit_heal_restart();
    logic [OW-1:0] e, a;
    restart = 1'b1; tick(); restart = 1'b0;
    checks++;
    if ({health_bcd, dead, enable} !== {8'h10, 1'b0, 5'b00000}) begin
      errors++;
      $display("FAIL restart_from_dead: got %h/%b/%b expected 10/0/00000", health_bcd, dead, enable);
    end
    damage = 4'd2;
    health_toggle = 1'b1; tick();
    health_toggle = 1'b0; tick();
    heal = 1'b1; tick(); heal = 1'b0;
    checks++;
    if (health_bcd !== 8'h08) begin
      errors++;
      $display("FAIL hit_plus_heal: got %h expected 08", health_bcd);
    end
    repeat (9) tick();
    hit_edge(4'd9);
    restart = 1'b1; tick(); restart = 1'b0;
    checks++;
    if ({health_bcd, dead, enable, invuln} !== {8'h10, 1'b0, 5'b00000, 1'b0}) begin
      errors++;
      $display("FAIL restart_clear: got %h/%b/%b/%b expected 10/0/00000/0", health_bcd, dead, enable, invuln);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL hit_heal_restart: got %h expected %h", a, e);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [OW-1:0] e, a;
    hit_edge(4'd4);
    tick(); tick();
    #3;
    reset = 1'b0;
    model_reset();
    #1;
    checks++;
    if (obs !== {8'h10, 1'b0, 1'b0, 5'b00000, 1'b0}) begin
      errors++;
      $display("FAIL async_reset: got %h expected %h", obs, {8'h10, 8'h00});
    end
    @(posedge clk); #1;
    checks++;
    if (obs !== model_vec()) begin
      errors++;
      $display("FAIL reset_held: got %h expected %h", obs, model_vec());
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (4) tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL post_reset: got %h expected %h", a, e);
      end
    end
  endtask

  task automatic test_random();
    logic [OW-1:0] e, a;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 2) == 0) health_toggle = ~health_toggle;
      damage  = 4'($urandom_range(0, 15));
      heal    = ($urandom_range(0, 3) == 0);
      restart = ($urandom_range(0, 59) == 0);
      tick();
    end
    heal = 1'b0; restart = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL random: got %h expected %h", a, e);
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_hit_invuln();
    test_borrow_heal();
    test_death();
    test_hit_heal_restart();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/health_tracker.md
Name: health_tracker

Overview:
- Parametrised player-health controller for the asteroid game; successor to the two-digit hit counter.
- Holds health as DIGITS packed BCD digits and applies variable damage from a synchronised hit strobe.
- Adds heal, an invulnerability window and a restart.
- On death, drives ENABLES game-over enables to the display/control logic.

Parameters:
- DIGITS, 2, number of BCD digits in health_bcd.
- START_HEALTH, 10, decimal health loaded at reset/restart; 1 <= START_HEALTH <= MAX_HEALTH.
- MAX_HEALTH, 99, decimal saturation ceiling for heal; MAX_HEALTH <= 10^DIGITS - 1.
- ENABLES, 5, width of game-over enable vector.
- INVULN_CYCLES, 8, clk cycles of hit immunity after an accepted non-fatal hit; 0 disables the window.
- REGEN_CYCLES, 1024, regeneration period (used only with the optional feature).

Ports:
- clk  in  1  system clock, all logic rising-edge.
- reset  in  1  asynchronous, active-low; clears the block when 0.
- health_toggle  in  1  raw asynchronous hit input; rising edge = one hit.
- damage  in  4  BCD damage per hit, sampled when the hit is accepted; 0 is treated as 1; values 10-15 are treated as 9.
- heal  in  1  synchronous pulse; +1 health per cycle high.
- restart  in  1  synchronous pulse; reload START_HEALTH from any state.
- health_bcd  out  4*DIGITS  registered BCD health; digit 0 in [3:0].
- invuln  out  1  high while in INVULN.
- dead  out  1  high while in DEAD.
- enable  out  ENABLES  all ones in DEAD, else all zeros.
- hit_ack  out  1  one-cycle pulse on each accepted hit.

Behaviour:
- Reset (reset=0), asynchronous:
  - health_bcd = START_HEALTH in BCD; state ALIVE.
  - invuln, dead, hit_ack = 0; enable = 0; cooldown counter = 0.
  - Sync flops s1/s2/s3 are forced to 1 so a toggle held high across reset release creates no hit.
- Synchroniser and hit detection:
  - health_toggle -> s1 -> s2 -> s3.
  - hit = s2 & ~s3.
  - A toggle first sampled high at edge k makes hit true for the cycle after edge k+1; it is applied at edge k+2.
- States:
  - ALIVE:
    - Hit with damage < health: health -= damage, hit_ack = 1. If INVULN_CYCLES > 0, load the cooldown counter with INVULN_CYCLES and go to INVULN; otherwise stay in ALIVE.
    - Hit with damage >= health: health = 0, hit_ack = 1, go to DEAD.
  - INVULN:
    - invuln = 1. Hits are dropped (no hit_ack, not queued).
    - Counter decrements each cycle; on the cycle it reaches 0, go to ALIVE. Exactly INVULN_CYCLES cycles with invuln=1.
    - Heal is allowed.
  - DEAD:
    - dead = 1, enable = all ones, health_bcd = 0.
    - Hit, heal and regen are ignored. Exit only via restart or reset.
- Arithmetic:
  - BCD subtract/add with borrow/carry across all DIGITS digits; output is always valid BCD.
  - Heal saturates at MAX_HEALTH.
  - health never underflows below 0.
- Simultaneous events, priority:
  - restart > hit > heal > regen.
  - Hit and heal in the same cycle: the hit is applied and the heal is dropped.
  - Restart in any state: ALIVE, START_HEALTH, enables cleared, cooldown cleared, next cycle.
- Latency:
  - health_bcd, dead, invuln and enable update on the same edge that applies the event.
  - hit_ack is high in the following cycle.

Optional Feature:
- HEALTH_REGEN_EN defined: a free-running counter in ALIVE adds 1 health every REGEN_CYCLES cycles while health < MAX_HEALTH.
  - The counter resets to 0 on an accepted hit, on restart, and while in INVULN/DEAD.
  - Regen is dropped if a hit or heal occurs in the same cycle.
- HEALTH_REGEN_EN undefined: no regen counter is present; health changes only via hit, heal, restart or reset.

Test Plan:
- Reset release with health_toggle held high -> no hit_ack; health_bcd = 0x10, dead=0, enable=00000.
- damage=3, one toggle edge -> health 10 -> 07, hit_ack one cycle, invuln=1 for exactly 8 cycles; a second edge inside the window leaves health at 07.
- Health 12, damage=3 -> 09 (BCD borrow across digits); then heal x2 -> 11; heal at 99 stays 99.
- Health 05, damage=7 -> health 00, dead=1, enable=11111; later heal and toggle edges have no effect.
- Same cycle hit (damage=2) + heal at health 10 -> 08; restart while DEAD -> 10, dead=0, enable=00000 next cycle.
- Assert reset low mid-INVULN -> outputs return to reset values immediately (asynchronous); with HEALTH_REGEN_EN, REGEN_CYCLES=16 at health 05 -> 06 after 16 ALIVE cycles.
